// File: rtl/cordic_pkg.sv
// Shared defaults, FSM encoding and tag type for the two-requester CORDIC arbiter.
package cordic_pkg;

  localparam int DATA_WIDTH_DEF     = 15;
  localparam int CORDIC_LATENCY_DEF = 14;
  localparam int ISSUE_INTERVAL_DEF = 2;
  localparam int NUM_REQ            = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/cordic_tag_pipe.sv
// Tag delay line running alongside the shared CORDIC; stage 0 lines up with in_X/in_Y.
module cordic_tag_pipe
  import cordic_pkg::*;
#(
  parameter int DEPTH = CORDIC_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_vld
);

  tag_t [DEPTH:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[DEPTH-1:0], tag_in};
  end

  assign tag_out = vld_pipe[DEPTH];

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i <= DEPTH; i++) any_vld = any_vld | vld_pipe[i].vld;
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC between two requesters;
// results are routed back by a tag delay line matched to the CORDIC latency.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int CORDIC_LATENCY = CORDIC_LATENCY_DEF,
  parameter int ISSUE_INTERVAL = ISSUE_INTERVAL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [DATA_WIDTH-1:0] req_X0,
  input  logic [DATA_WIDTH-1:0] req_Y0,
  input  logic [DATA_WIDTH-1:0] req_X1,
  input  logic [DATA_WIDTH-1:0] req_Y1,
  output logic [DATA_WIDTH-1:0] in_X,
  output logic [DATA_WIDTH-1:0] in_Y,
  input  logic [DATA_WIDTH-1:0] out_theta,
  input  logic [DATA_WIDTH-1:0] out_X_1,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [DATA_WIDTH-1:0] resp_theta,
  output logic [DATA_WIDTH-1:0] resp_X,
  output logic                  busy
);

  // Gap counter holds ISSUE_INTERVAL-2 down to 0, i.e. ISSUE_INTERVAL-1 GAP cycles.
  localparam int GW       = (ISSUE_INTERVAL > 2) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int GAP_LOAD = (ISSUE_INTERVAL > 1) ? ISSUE_INTERVAL - 2 : 0;

  logic [0:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          ptr;
  logic          grant;
  logic          gnt_id;
  tag_t          tag_in;
  tag_t          tag_out;

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE) begin
      if (&req_valid) req_ready = ptr ? 2'b10 : 2'b01;
      else            req_ready = req_valid;
    end
  end

  assign grant  = |(req_valid & req_ready);
  assign gnt_id = req_ready[1];
  assign tag_in = '{vld: grant, id: gnt_id};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      ptr     <= 1'b0;
      in_X    <= '0;
      in_Y    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (grant && ISSUE_INTERVAL > 1) begin
          state   <= ST_GAP;
          gap_cnt <= GW'(GAP_LOAD);
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      if (grant) begin
        ptr  <= ~gnt_id;
        in_X <= gnt_id ? req_X1 : req_X0;
        in_Y <= gnt_id ? req_Y1 : req_Y0;
      end
    end
  end

  cordic_tag_pipe #(.DEPTH(CORDIC_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .any_vld (busy)
  );

  // Results are only forwarded in the cycle their tag emerges; zero otherwise.
  always_comb begin
    resp_valid = '0;
    resp_theta = '0;
    resp_X     = '0;
    if (tag_out.vld) begin
      resp_valid[tag_out.id] = 1'b1;
      resp_theta             = out_theta;
      resp_X                 = out_X_1;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench: two arbiters (issue interval 2 and 1) against delay-line CORDIC models,
// responses checked from an expectation queue filled when grants are driven.
module tb_cordic_arbiter;

  localparam int DW = 15;
  localparam int L  = 14;

  typedef struct {
    logic          id;
    logic [DW-1:0] th;
    logic [DW-1:0] x;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT a: default issue interval
  logic [1:0]    va, ra, rva;
  logic [DW-1:0] xa0, ya0, xa1, ya1, ixa, iya, ota, oxa, rta, rxa;
  logic          busy_a;
  logic [DW-1:0] dxa [L];
  logic [DW-1:0] dya [L];

  cordic_arbiter dut_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(ra),
    .req_X0(xa0), .req_Y0(ya0), .req_X1(xa1), .req_Y1(ya1),
    .in_X(ixa), .in_Y(iya), .out_theta(ota), .out_X_1(oxa),
    .resp_valid(rva), .resp_theta(rta), .resp_X(rxa), .busy(busy_a)
  );

  // DUT b: issue every cycle
  logic [1:0]    vb, rb, rvb;
  logic [DW-1:0] xb0, yb0, xb1, yb1, ixb, iyb, otb, oxb, rtb, rxb;
  logic          busy_b;
  logic [DW-1:0] dxb [L];
  logic [DW-1:0] dyb [L];

  cordic_arbiter #(.ISSUE_INTERVAL(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rb),
    .req_X0(xb0), .req_Y0(yb0), .req_X1(xb1), .req_Y1(yb1),
    .in_X(ixb), .in_Y(iyb), .out_theta(otb), .out_X_1(oxb),
    .resp_valid(rvb), .resp_theta(rtb), .resp_X(rxb), .busy(busy_b)
  );

  // CORDIC models: pure L-cycle delay of the presented operands
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      dxa[i] <= dxa[i-1]; dya[i] <= dya[i-1];
      dxb[i] <= dxb[i-1]; dyb[i] <= dyb[i-1];
    end
    dxa[0] <= ixa; dya[0] <= iya;
    dxb[0] <= ixb; dyb[0] <= iyb;
  end
  assign ota = dxa[L-1];
  assign oxa = dya[L-1];
  assign otb = dxb[L-1];
  assign oxb = dyb[L-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboards
  always @(negedge clk) begin
    if (!rst) begin
      if (rva != 2'b00) begin
        if (qa.size() == 0) chk("a_spurious_resp", {30'd0, rva}, 32'd0);
        else begin
          exp_t e;
          e = qa.pop_front();
          chk("a_resp_valid", {30'd0, rva}, e.id ? 32'd2 : 32'd1);
          chk("a_resp_theta", {17'd0, rta}, {17'd0, e.th});
          chk("a_resp_x",     {17'd0, rxa}, {17'd0, e.x});
          chk("a_resp_cycle", cyc, e.cyc);
        end
      end else chk("a_resp_zero", {2'd0, rta, rxa}, 32'd0);
      if (rvb != 2'b00) begin
        if (qb.size() == 0) chk("b_spurious_resp", {30'd0, rvb}, 32'd0);
        else begin
          exp_t e;
          e = qb.pop_front();
          chk("b_resp_valid", {30'd0, rvb}, e.id ? 32'd2 : 32'd1);
          chk("b_resp_theta", {17'd0, rtb}, {17'd0, e.th});
          chk("b_resp_x",     {17'd0, rxb}, {17'd0, e.x});
          chk("b_resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // One cycle on DUT a: drive valid, check ready, record expected result if granted
  task automatic step_a(input logic [1:0] v, input logic [1:0] exp_rdy, input bit push);
    exp_t e;
    va = v;
    #1;
    chk("a_ready", {30'd0, ra}, {30'd0, exp_rdy});
    if (push && exp_rdy != 2'b00) begin
      e.id  = exp_rdy[1];
      e.th  = exp_rdy[1] ? xa1 : xa0;
      e.x   = exp_rdy[1] ? ya1 : ya0;
      e.cyc = cyc + 1 + L;
      qa.push_back(e);
    end
    @(negedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (qa.size() + qb.size()) != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain_timeout", qa.size() + qb.size(), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_resp_a", {30'd0, rva}, 32'd0);
    qa.delete();
    qb.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    logic signed [DW-1:0] neg [3];
    exp_t e;
    neg[0] = -15'sd536; neg[1] = -15'sd2492; neg[2] = -15'sd3784;
    va = 2'b00; vb = 2'b00;
    xa0 = '0; ya0 = '0; xa1 = '0; ya1 = '0;
    xb0 = '0; yb0 = '0; xb1 = '0; yb1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_x", {17'd0, ixa}, 32'd0);
    chk("rst_in_y", {17'd0, iya}, 32'd0);
    chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
    chk("rst_resp", {28'd0, rva, rvb}, 32'd0);
    chk("rst_resp_data", {2'd0, rta, rxa}, 32'd0);
    chk("rst_ready_idle", {30'd0, ra}, 32'd0);
    va = 2'b10; #1;
    chk("rst_ready_lone", {30'd0, ra}, 32'd2);
    va = 2'b00;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Single request
    xa0 = 15'd4060; ya0 = 15'd536;
    step_a(2'b01, 2'b01, 1'b1);
    chk("single_in_x", {17'd0, ixa}, 32'd4060);
    chk("single_in_y", {17'd0, iya}, 32'd536);
    chk("single_busy", {31'd0, busy_a}, 32'd1);
    step_a(2'b00, 2'b00, 1'b0);
    drain();
    @(negedge clk); #1;
    chk("single_busy_after", {31'd0, busy_a}, 32'd0);

    // Contention from a fresh pointer
    pulse_rst();
    xa0 = 15'd3248; ya0 = 15'd100; xa1 = 15'd1568; ya1 = 15'd200;
    for (int k = 0; k < 4; k++) begin
      step_a(2'b11, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
      step_a(2'b11, 2'b00, 1'b0);
    end
    step_a(2'b00, 2'b00, 1'b0);

    // Gap: requester 1 waits out the gap; requester 0 drops before ready
    xa0 = 15'd777; ya0 = 15'd55; xa1 = 15'd999; ya1 = 15'd66;
    step_a(2'b01, 2'b01, 1'b1);
    step_a(2'b10, 2'b00, 1'b0);
    step_a(2'b10, 2'b10, 1'b1);
    step_a(2'b01, 2'b00, 1'b0);
    step_a(2'b00, 2'b00, 1'b0);
    step_a(2'b00, 2'b00, 1'b0);
    drain();

    // Reset mid-flight discards the three outstanding operations
    for (int k = 0; k < 3; k++) begin
      xa0 = neg[k]; ya0 = 15'd10 + 15'(k);
      step_a(2'b01, 2'b01, 1'b0);
      if (k < 2) step_a(2'b00, 2'b00, 1'b0);
    end
    chk("neg_in_x", {17'd0, ixa}, {17'd0, 15'h7138});
    chk("inflight_busy", {31'd0, busy_a}, 32'd1);
    repeat (4) step_a(2'b00, 2'b00, 1'b0);
    pulse_rst();
    chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
    xa0 = 15'd1234; ya0 = 15'd4321; xa1 = 15'd2222; ya1 = 15'd3333;
    step_a(2'b11, 2'b01, 1'b1);
    step_a(2'b00, 2'b00, 1'b0);
    repeat (L + 4) begin
      @(negedge clk); #1;
    end
    drain();

    // Back-to-back on the single-cycle issue arbiter
    for (int k = 0; k < 12; k++) begin
      xb0 = 15'(100 * k + 7); yb0 = 15'(50 * k + 3);
      vb = 2'b01;
      #1;
      chk("b_ready", {30'd0, rb}, 32'd1);
      e.id = 1'b0; e.th = xb0; e.x = yb0; e.cyc = cyc + 1 + L;
      qb.push_back(e);
      @(negedge clk); #1;
    end
    vb = 2'b00;
    chk("b_busy", {31'd0, busy_b}, 32'd1);
    drain();
    @(negedge clk); #1;
    chk("b_busy_after", {31'd0, busy_b}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
